// File: rtl/led_ctrl_pkg.sv
// Shared types and widths for the LED pattern controller.
package led_ctrl_pkg;
  typedef enum logic [1:0] {OP_SET = 2'd0, OP_BLINK = 2'd1, OP_CHASE = 2'd2, OP_STOP = 2'd3} op_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STATIC = 2'd1, ST_BLINK = 2'd2, ST_CHASE = 2'd3} state_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/tick_gen.sv
// Pattern timebase: counts 0..TICK_DIV-1 and flags the wrap cycle.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 32'd1;
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_ctrl.sv
// Command-driven LED pattern scheduler: SET / BLINK / CHASE / STOP over valid/ready,
// with a divided-clock tick stepping the running pattern.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [7:0]       leds,
  output logic             busy,
  output logic             done
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("led_pattern_ctrl: TICK_DIV must be at least 2");
  end

  state_t           state_q, state_d;
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept, tick;
  op_t              op;

  assign op     = op_t'(cmd_op);
  assign accept = cmd_valid && ready_q;

  // An accept restarts the timebase so the first step lands TICK_DIV cycles later.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      leds_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    done_d  = 1'b0;
    if (accept) begin
      ready_d = 1'b0;
      case (op)
        OP_SET: begin
          leds_d  = cmd_mask;
          state_d = ST_STATIC;
          done_d  = 1'b1;
        end
        OP_BLINK: begin
          leds_d  = cmd_mask;
          mask_d  = cmd_mask;
          cnt_d   = cmd_count;
          state_d = ST_BLINK;
        end
        OP_CHASE: begin
          leds_d  = cmd_mask;
          cnt_d   = cmd_count;
          state_d = ST_CHASE;
        end
        OP_STOP: begin
          leds_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end else if (tick && (state_q == ST_BLINK || state_q == ST_CHASE)) begin
      // A count of 0 means run until preempted, so only 1 terminates.
      if (cnt_q == CNT_W'(1)) begin
        leds_d  = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        leds_d = (state_q == ST_BLINK) ? (leds_q ^ mask_q) : {leds_q[6:0], leds_q[7]};
      end
    end
  end

  assign leds      = leds_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_BLINK) || (state_q == ST_CHASE);
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised and directed checking of led_pattern_ctrl against a cycle-level reference model.
module tb_led_pattern_ctrl;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_STATIC = 1, M_BLINK = 2, M_CHASE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_mask = 8'd0;
  logic [7:0] cmd_count = 8'd0;
  logic [7:0] leds;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  bit started = 1'b0;

  // reference model state
  int         m_mode = M_IDLE;
  logic [7:0] m_leds = 8'd0;
  logic [7:0] m_bmask = 8'd0;
  int         m_cnt = 0;
  int         m_age = 0;
  bit         m_ready = 1'b0;
  bit         m_done = 1'b0;

  led_pattern_ctrl #(.CLK_FREQ(16), .TICK_HZ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: ticks occur every TD cycles counted from the last reset or accept.
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_mode = M_IDLE; m_leds = 8'd0; m_cnt = 0; m_age = 0;
      m_ready = 1'b0; m_done = 1'b0;
    end else begin
      m_age++;
      m_done = 1'b0;
      if (cmd_valid && m_ready) begin
        m_ready = 1'b0;
        m_age = 0;
        case (cmd_op)
          2'd0: begin m_leds = cmd_mask; m_mode = M_STATIC; m_done = 1'b1; end
          2'd1: begin m_leds = cmd_mask; m_bmask = cmd_mask; m_cnt = cmd_count; m_mode = M_BLINK; end
          2'd2: begin m_leds = cmd_mask; m_cnt = cmd_count; m_mode = M_CHASE; end
          default: begin m_leds = 8'd0; m_mode = M_IDLE; end
        endcase
      end else begin
        m_ready = 1'b1;
        if ((m_age % TD == 0) && (m_mode == M_BLINK || m_mode == M_CHASE)) begin
          if (m_cnt == 1) begin
            m_leds = 8'd0; m_mode = M_IDLE; m_cnt = 0; m_done = 1'b1;
          end else begin
            if (m_cnt > 0) m_cnt--;
            if (m_mode == M_BLINK) m_leds = m_leds ^ m_bmask;
            else m_leds = {m_leds[6:0], m_leds[7]};
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_leds", {24'd0, leds}, {24'd0, m_leds});
      chk("model_busy", {31'd0, busy}, {31'd0, (m_mode == M_BLINK || m_mode == M_CHASE)});
      chk("model_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
    end
    if (done === 1'b1) done_seen++;
  end

  // Returns at the falling edge just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] mask, input logic [7:0] count);
    int n;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_count = count;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_leds", {24'd0, leds}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'h1);

    // SET 0xA5
    issue(2'd0, 8'hA5, 8'd0);
    chk("set_leds", {24'd0, leds}, 32'hA5);
    chk("set_done", {31'd0, done}, 32'h1);
    chk("set_ready_low", {31'd0, cmd_ready}, 32'h0);
    wait_neg(1);
    chk("set_done_end", {31'd0, done}, 32'h0);
    chk("set_ready_back", {31'd0, cmd_ready}, 32'h1);
    wait_neg(20);
    chk("set_stable", {24'd0, leds}, 32'hA5);

    // BLINK 0x81 count 3
    issue(2'd1, 8'h81, 8'd3);
    chk("blink_p0", {24'd0, leds}, 32'h81);
    chk("blink_busy", {31'd0, busy}, 32'h1);
    wait_neg(3);  chk("blink_p3", {24'd0, leds}, 32'h81);
    wait_neg(1);  chk("blink_p4", {24'd0, leds}, 32'h00);
    wait_neg(4);  chk("blink_p8", {24'd0, leds}, 32'h81);
    wait_neg(3);  chk("blink_p11_busy", {31'd0, busy}, 32'h1);
    chk("blink_p11_done", {31'd0, done}, 32'h0);
    wait_neg(1);  chk("blink_p12", {24'd0, leds}, 32'h00);
    chk("blink_p12_busy", {31'd0, busy}, 32'h0);
    chk("blink_done", {31'd0, done}, 32'h1);
    wait_neg(1);  chk("blink_done_end", {31'd0, done}, 32'h0);

    // CHASE 0x80 forever, then STOP
    issue(2'd2, 8'h80, 8'd0);
    chk("chase_p0", {24'd0, leds}, 32'h80);
    wait_neg(4);  chk("chase_p4", {24'd0, leds}, 32'h01);
    wait_neg(4);  chk("chase_p8", {24'd0, leds}, 32'h02);
    d0 = done_seen;
    wait_neg(40);
    chk("chase_no_done", done_seen - d0, 32'd0);
    chk("chase_busy", {31'd0, busy}, 32'h1);
    issue(2'd3, 8'hFF, 8'd7);
    chk("stop_leds", {24'd0, leds}, 32'h0);
    chk("stop_busy", {31'd0, busy}, 32'h0);
    chk("stop_done", {31'd0, done}, 32'h0);

    // SET lands on the final BLINK tick
    d0 = done_seen;
    issue(2'd1, 8'hFF, 8'd2);
    wait_neg(6);
    issue(2'd0, 8'h3C, 8'd0);
    chk("preempt_leds", {24'd0, leds}, 32'h3C);
    chk("preempt_busy", {31'd0, busy}, 32'h0);
    chk("preempt_done", {31'd0, done}, 32'h1);
    wait_neg(6);
    chk("preempt_one_done", done_seen - d0, 32'd1);
    chk("preempt_static", {24'd0, leds}, 32'h3C);

    // reset in the middle of a BLINK
    d0 = done_seen;
    issue(2'd1, 8'h0F, 8'd5);
    wait_neg(9);
    chk("mid_leds_pre", {24'd0, leds}, 32'h0F);
    rst = 1'b1;
    wait_neg(1);
    chk("mid_rst_leds", {24'd0, leds}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'h0);
    rst = 1'b0;
    wait_neg(12);
    chk("mid_rst_no_done", done_seen - d0, 32'd0);
    issue(2'd0, 8'h5A, 8'd0);
    chk("after_rst_set", {24'd0, leds}, 32'h5A);
    chk("after_rst_done", {31'd0, done}, 32'h1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 249) == 0);
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cmd_count = 8'($urandom_range(0, 5));
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    wait_neg(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
